rgb2raw_bayer_tx: RTL and testbench

- Re-mosaics a packed RGB pixel stream into a single-channel 10-bit Bayer stream.
- Output uses CCD_DATA/FVAL/LVAL/X_Cont/Y_Cont timing, so it feeds the existing line-buffer + bin RGB path unchanged.
- Uses: camera emulation, loopback test of the auto-focus pipeline without the D8M sensor, and replay of stored frames.
- Owns frame/line timing (lead, blanking, trail); pulls pixels from the source with a valid/ready handshake.

---
 rtl/rgb2raw_pkg.sv | 30 +++
 rtl/bayer_sel.sv | 48 ++++
 rtl/rgb2raw_bayer_tx.sv | 172 +++++++++++++++++
 tb/tb_rgb2raw_bayer_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2raw_pkg.sv
// Shared types for the RGB-to-Bayer transmitter: FSM states, CFA orders,
// colour selection and the 8-to-10-bit sample expansion.
package rgb2raw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_ACTIVE,
      ST_HBLANK,
      ST_TRAIL,
      ST_VBLANK
   } state_t;

   // CFA order of (row0x0, row0x1, row1x0, row1x1)
   localparam logic [1:0] PAT_GRBG = 2'd0;
   localparam logic [1:0] PAT_RGGB = 2'd1;
   localparam logic [1:0] PAT_BGGR = 2'd2;
   localparam logic [1:0] PAT_GBRG = 2'd3;

   typedef enum logic [1:0] {
      SEL_R,
      SEL_G,
      SEL_B
   } sel_t;

   function automatic logic [9:0] expand_8to10(input logic [7:0] c);
      return {c, c[7:6]};
   endfunction

endpackage

// File: rtl/bayer_sel.sv
// Picks the R, G or B channel for one Bayer site and expands it to 10 bits.
// Purely combinational; shared with the test-pattern generator.
module bayer_sel
   import rgb2raw_pkg::*;
(
   input  logic [1:0] pat_i,
   input  logic       row0_i,
   input  logic       col0_i,
   input  logic [7:0] r_i,
   input  logic [7:0] g_i,
   input  logic [7:0] b_i,
   output logic [9:0] sample_o
);

   logic [1:0] idx;
   sel_t       sel;

   always_comb begin
      idx = {row0_i, col0_i};
      sel = SEL_G;
      case (pat_i)
         PAT_GRBG: begin
            if (idx == 2'd1)      sel = SEL_R;
            else if (idx == 2'd2) sel = SEL_B;
         end
         PAT_RGGB: begin
            if (idx == 2'd0)      sel = SEL_R;
            else if (idx == 2'd3) sel = SEL_B;
         end
         PAT_BGGR: begin
            if (idx == 2'd0)      sel = SEL_B;
            else if (idx == 2'd3) sel = SEL_R;
         end
         PAT_GBRG: begin
            if (idx == 2'd1)      sel = SEL_B;
            else if (idx == 2'd2) sel = SEL_R;
         end
         default: sel = SEL_G;
      endcase

      case (sel)
         SEL_R:   sample_o = expand_8to10(r_i);
         SEL_B:   sample_o = expand_8to10(b_i);
         default: sample_o = expand_8to10(g_i);
      endcase
   end

endmodule

// File: rtl/rgb2raw_bayer_tx.sv
// Re-mosaics an RGB pixel stream into a 10-bit Bayer stream with FVAL/LVAL framing.
// One-cycle pixel latency; oREADY only in ACTIVE, and source stalls become LVAL gaps.
module rgb2raw_bayer_tx
   import rgb2raw_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned H_BLANK   = 160,
   parameter int unsigned FV_LEAD   = 4,
   parameter int unsigned FV_TRAIL  = 4,
   parameter int unsigned V_BLANK   = 16,
   parameter int unsigned BAYER_PAT = 0
)(
   input  logic        CCD_PIXCLK,
   input  logic        RST,
   input  logic        START,
   input  logic [7:0]  iRed,
   input  logic [7:0]  iGreen,
   input  logic [7:0]  iBlue,
   input  logic        iDVAL,
   output logic        oREADY,
   output logic [9:0]  CCD_DATA,
   output logic        CCD_FVAL,
   output logic        CCD_LVAL,
   output logic [15:0] X_Cont,
   output logic [15:0] Y_Cont,
   output logic        oUNDERRUN,
   output logic        oFRAME_DONE
);

   if (H_ACTIVE < 1 || H_ACTIVE > 65535 || V_ACTIVE < 1 || V_ACTIVE > 65535 ||
       H_BLANK < 1 || FV_LEAD < 1 || FV_TRAIL < 1 || V_BLANK < 1) begin : g_bad_params
      $error("rgb2raw_bayer_tx: illegal timing parameters");
   end

   state_t      state_q, state_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [15:0] col_q, col_d;
   logic [15:0] row_q, row_d;
   logic [9:0]  data_q, data_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic        fval_q, fval_d;
   logic        lval_q, lval_d;
   logic        under_q, under_d;
   logic        done_q, done_d;

   logic [9:0]  sample;
   logic [15:0] tlim;
   logic        tdone;
   logic        accept;

   bayer_sel u_bayer_sel (
      .pat_i    (2'(BAYER_PAT)),
      .row0_i   (row_q[0]),
      .col0_i   (col_q[0]),
      .r_i      (iRed),
      .g_i      (iGreen),
      .b_i      (iBlue),
      .sample_o (sample)
   );

   assign accept = iDVAL && (state_q == ST_ACTIVE);

   always_comb begin
      case (state_q)
         ST_LEAD:   tlim = 16'(FV_LEAD - 1);
         ST_HBLANK: tlim = 16'(H_BLANK - 1);
         ST_TRAIL:  tlim = 16'(FV_TRAIL - 1);
         ST_VBLANK: tlim = 16'(V_BLANK - 1);
         default:   tlim = 16'd0;
      endcase
      tdone = (tcnt_q == tlim);
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q + 16'd1;
      col_d   = col_q;
      row_d   = row_q;
      data_d  = data_q;
      x_d     = x_q;
      y_d     = y_q;
      lval_d  = 1'b0;
      under_d = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            col_d = 16'd0;
            row_d = 16'd0;
            x_d   = 16'd0;
            y_d   = 16'd0;
            if (START) state_d = ST_LEAD;
         end
         ST_LEAD:   if (tdone) state_d = ST_ACTIVE;
         ST_ACTIVE: begin
            if (accept) begin
               lval_d = 1'b1;
               data_d = sample;
               x_d    = col_q;
               y_d    = row_q;
               col_d  = col_q + 16'd1;
               if (col_q == 16'(H_ACTIVE - 1)) begin
                  col_d = 16'd0;
                  if (row_q == 16'(V_ACTIVE - 1)) begin
                     state_d = ST_TRAIL;
                  end else begin
                     row_d   = row_q + 16'd1;
                     state_d = ST_HBLANK;
                  end
               end
            end else begin
               under_d = 1'b1;
            end
         end
         ST_HBLANK: if (tdone) state_d = ST_ACTIVE;
         ST_TRAIL:  if (tdone) state_d = ST_VBLANK;
         ST_VBLANK: begin
            if (tdone) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Every timed state counts from zero on entry.
      if (state_d != state_q) tcnt_d = 16'd0;

      fval_d = (state_d == ST_LEAD) || (state_d == ST_ACTIVE) ||
               (state_d == ST_HBLANK) || (state_d == ST_TRAIL);
   end

   always_ff @(posedge CCD_PIXCLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         tcnt_q  <= 16'd0;
         col_q   <= 16'd0;
         row_q   <= 16'd0;
         data_q  <= 10'd0;
         x_q     <= 16'd0;
         y_q     <= 16'd0;
         fval_q  <= 1'b0;
         lval_q  <= 1'b0;
         under_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         data_q  <= data_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fval_q  <= fval_d;
         lval_q  <= lval_d;
         under_q <= under_d;
         done_q  <= done_d;
      end
   end

   assign oREADY      = (state_q == ST_ACTIVE);
   assign CCD_DATA    = data_q;
   assign CCD_FVAL    = fval_q;
   assign CCD_LVAL    = lval_q;
   assign X_Cont      = x_q;
   assign Y_Cont      = y_q;
   assign oUNDERRUN   = under_q;
   assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_rgb2raw_bayer_tx.sv
// Scoreboard bench for rgb2raw_bayer_tx: two instances (GRBG and RGGB) share one stimulus stream.
module tb_rgb2raw_bayer_tx;

   localparam int H     = 4;
   localparam int V     = 2;
   localparam int HB    = 2;
   localparam int LEAD  = 3;
   localparam int TRAIL = 1;
   localparam int VB    = 2;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [9:0]  d0;
      logic [9:0]  d1;
   } exp_t;

   logic clk = 1'b0;
   logic rst, start, dval;
   logic [7:0] r, g, b;

   logic        rdy0, fval0, lval0, und0, done0;
   logic        rdy1, fval1, lval1, und1, done1;
   logic [9:0]  data0, data1;
   logic [15:0] x0, y0, x1, y1;

   int errors = 0;
   int checks = 0;
   exp_t sb_q[$];

   int pix_total  = 0;
   int pix_base   = 0;
   int exp_stalls = 0;
   int n_fval = 0, n_lval = 0, n_und = 0, n_done = 0;
   int low_run = 0, line_gap = -1, gap_x2 = -1, since_fall = -1, done_after = -1;
   logic [15:0] last_x = 16'd0, last_y = 16'd0;
   logic prev_fval = 1'b0;

   always #5 clk = ~clk;

   rgb2raw_bayer_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .FV_LEAD(LEAD),
                      .FV_TRAIL(TRAIL), .V_BLANK(VB), .BAYER_PAT(0)) u_dut0 (
      .CCD_PIXCLK(clk), .RST(rst), .START(start), .iRed(r), .iGreen(g), .iBlue(b),
      .iDVAL(dval), .oREADY(rdy0), .CCD_DATA(data0), .CCD_FVAL(fval0), .CCD_LVAL(lval0),
      .X_Cont(x0), .Y_Cont(y0), .oUNDERRUN(und0), .oFRAME_DONE(done0));

   rgb2raw_bayer_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .FV_LEAD(LEAD),
                      .FV_TRAIL(TRAIL), .V_BLANK(VB), .BAYER_PAT(1)) u_dut1 (
      .CCD_PIXCLK(clk), .RST(rst), .START(start), .iRed(r), .iGreen(g), .iBlue(b),
      .iDVAL(dval), .oREADY(rdy1), .CCD_DATA(data1), .CCD_FVAL(fval1), .CCD_LVAL(lval1),
      .X_Cont(x1), .Y_Cont(y1), .oUNDERRUN(und1), .oFRAME_DONE(done1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: CFA letter at (row, col) parity, channel scaled 8->10 bits by c*4 + c/64.
   function automatic logic [9:0] model_sample(input int pat, input int row, input int col,
                                                input logic [7:0] rr, input logic [7:0] gg,
                                                input logic [7:0] bb);
      string cfa;
      byte   ch;
      int    c;
      case (pat)
         0:       cfa = "GRBG";
         1:       cfa = "RGGB";
         2:       cfa = "BGGR";
         default: cfa = "GBRG";
      endcase
      ch = cfa[(row % 2) * 2 + (col % 2)];
      if (ch == "R")      c = int'(rr);
      else if (ch == "B") c = int'(bb);
      else                c = int'(gg);
      return 10'(c * 4 + c / 64);
   endfunction

   // Stimulus side: every handshake pushes its expected strobe into the scoreboard.
   initial begin
      exp_t e;
      int   n;
      forever begin
         @(negedge clk);
         if (!rst && rdy0 && dval) begin
            n    = pix_total - pix_base;
            e.x  = 16'(n % H);
            e.y  = 16'(n / H);
            e.d0 = model_sample(0, n / H, n % H, r, g, b);
            e.d1 = model_sample(1, n / H, n % H, r, g, b);
            sb_q.push_back(e);
            pix_total++;
         end else if (!rst && rdy0 && !dval) begin
            exp_stalls++;
         end
      end
   end

   // Monitor: pops on every LVAL strobe and tracks frame timing.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!prev_fval && fval0) begin
            line_gap = -1; gap_x2 = -1; done_after = -1;
            last_x = 16'd0; last_y = 16'd0;
         end
         if (fval0) n_fval++;
         if (und0) begin
            n_und++;
            chk("underrun_lval_low", 32'(lval0), 32'd0);
            chk("underrun_x_hold", 32'(x0), 32'(last_x));
            chk("underrun_y_hold", 32'(y0), 32'(last_y));
         end
         if (lval0) begin
            n_lval++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got strobe at x=%0d y=%0d, expected none", x0, y0);
            end else begin
               e = sb_q.pop_front();
               chk("x_cont", 32'(x0), 32'(e.x));
               chk("y_cont", 32'(y0), 32'(e.y));
               chk("data_grbg", 32'(data0), 32'(e.d0));
               chk("lval_rggb", 32'(lval1), 32'd1);
               chk("x_cont_rggb", 32'(x1), 32'(e.x));
               chk("data_rggb", 32'(data1), 32'(e.d1));
            end
            if (y0 == last_y + 16'd1) line_gap = low_run;
            if (x0 == 16'd2 && y0 == 16'd0) gap_x2 = low_run;
            low_run = 0;
            last_x  = x0;
            last_y  = y0;
         end else begin
            low_run++;
         end
         if (prev_fval && !fval0) since_fall = 0;
         else if (since_fall >= 0) since_fall++;
         if (done0) begin
            n_done++;
            done_after = since_fall;
         end
         prev_fval = fval0;
      end
   end

   task automatic run_frame(input bit const_rgb, input int stall_at, input bit rand_dval,
                            input bit pulse_start, input int rst_at);
      int f0, l0, u0, d0, s0, budget, idx, stall_left, busy, stalls;
      bit pulsed_a, pulsed_t, fin, aborted;
      f0 = n_fval; l0 = n_lval; u0 = n_und; d0 = n_done; s0 = exp_stalls;
      stall_left = 2; pulsed_a = 0; pulsed_t = 0; fin = 0; aborted = 0; budget = 0;

      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b1;
      pix_base = pix_total;
      @(negedge clk);
      @(negedge clk);
      chk("start_to_fval", 32'(fval0), 32'd1);

      while (!fin && budget < 300) begin
         @(posedge clk); #1;
         budget++;
         start = 1'b0;
         idx = pix_total - pix_base;
         if (const_rgb) begin
            r = 8'hFF; g = 8'h80; b = 8'h01;
         end else begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
         end
         dval = 1'b1;
         if (rand_dval && rdy0) dval = ($urandom_range(0, 3) != 0);
         if (stall_at >= 0 && idx == stall_at && stall_left > 0 && rdy0) begin
            dval = 1'b0;
            stall_left--;
         end
         if (pulse_start && rdy0 && !pulsed_a) begin
            start = 1'b1; pulsed_a = 1;
         end
         if (pulse_start && idx == H * V && !pulsed_t) begin
            start = 1'b1; pulsed_t = 1;
         end
         if (rst_at >= 0 && idx == rst_at && rdy0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk); #1;
            chk("midrst_fval", 32'(fval0), 32'd0);
            chk("midrst_lval", 32'(lval0), 32'd0);
            chk("midrst_x", 32'(x0), 32'd0);
            chk("midrst_y", 32'(y0), 32'd0);
            chk("midrst_ready", 32'(rdy0), 32'd0);
            chk("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
            aborted = 1;
            fin = 1;
         end else begin
            @(negedge clk);
            if (done0) fin = 1;
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: got no oFRAME_DONE, expected one within 300 cycles");
      end
      if (aborted || !fin) return;

      #1;
      stalls = exp_stalls - s0;
      chk("fval_cycles", 32'(n_fval - f0), 32'(LEAD + H * V + stalls + HB * (V - 1) + TRAIL));
      chk("lval_strobes", 32'(n_lval - l0), 32'(H * V));
      chk("underruns", 32'(n_und - u0), 32'(stalls));
      chk("frame_done_count", 32'(n_done - d0), 32'd1);
      chk("done_after_fval_fall", 32'(done_after), 32'(VB));
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      if (!rand_dval) chk("line_gap", 32'(line_gap), 32'(HB));
      if (stall_at == 2) chk("stall_gap_x2", 32'(gap_x2), 32'd2);

      busy = 0;
      repeat (5) begin
         @(negedge clk);
         busy += int'(fval0) + int'(rdy0);
      end
      chk("idle_after_frame", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; dval = 1'b1;
      r = 8'hFF; g = 8'h80; b = 8'h01;
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("rst_outputs_grbg", {rdy0, fval0, lval0, und0, done0, data0, x0},
             32'd0);
         chk("rst_y_grbg", 32'(y0), 32'd0);
         chk("rst_outputs_rggb", {rdy1, fval1, lval1, und1, done1, data1, x1},
             32'd0);
      end

      run_frame(1'b1, -1, 1'b0, 1'b0, -1);
      run_frame(1'b1, 2, 1'b0, 1'b0, -1);
      run_frame(1'b1, -1, 1'b0, 1'b1, -1);
      run_frame(1'b0, -1, 1'b0, 1'b0, 6);
      run_frame(1'b0, -1, 1'b0, 1'b0, -1);
      for (int i = 0; i < 4; i++) run_frame(1'b0, -1, 1'b1, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
